// File: rtl/uart_pkg.sv
// uart_pkg: FSM encodings and timing math shared by the UART TX and RX.
// UART_TX_PARITY_EN adds the PARITY state to the transmitter encoding.
package uart_pkg;

   localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_t;
`endif

   function automatic int cycles_per_bit(
      input int clk_hz,
      input int bit_rate
   );
      return clk_hz / bit_rate;
   endfunction

   // Wide enough to hold the full bit period, not just its last index.
   function automatic int cnt_width(input int cpb);
      return $clog2(cpb + 1);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts one bit period while run is high, pulsing bit_done
// on its last cycle; the count restarts at every boundary and when idle.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CYCLES = 10
) (
   input  logic clk,
   input  logic resetn,
   input  logic run,
   output logic bit_done
);

   localparam int W = cnt_width(CYCLES);
   localparam logic [W-1:0] LAST = W'(CYCLES - 1);

   logic [W-1:0] cnt;

   assign bit_done = run && (cnt == LAST);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (!run || bit_done) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 UART transmitter with a registered TX pin.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int BIT_RATE  = 9600,
   parameter int CLK_HZ    = 100000000,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       resetn,
   output logic       uart_txd,
   input  logic       tx_en,
   input  logic [7:0] tx_data,
   output logic       tx_busy
);

   localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   tx_state_t  state, state_d;
   logic [7:0] shift, shift_d;
   logic [2:0] idx, idx_d;
   logic       txd_d;
   logic       run;
   logic       bit_done;
`ifdef UART_TX_PARITY_EN
   logic       par, par_d;
`endif

   assign run     = (state != ST_IDLE);
   assign tx_busy = run;

   uart_bit_timer #(
      .CYCLES(CPB)
   ) u_timer (
      .clk     (clk),
      .resetn  (resetn),
      .run     (run),
      .bit_done(bit_done)
   );

   // Outputs are computed for the next state so the pin itself is a flop.
   always_comb begin
      state_d = state;
      shift_d = shift;
      idx_d   = idx;
      txd_d   = uart_txd;
`ifdef UART_TX_PARITY_EN
      par_d   = par;
`endif
      unique case (state)
         ST_IDLE: begin
            txd_d = 1'b1;
            if (tx_en) begin
               state_d = ST_START;
               shift_d = tx_data;
               idx_d   = '0;
               txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
               par_d   = ^tx_data;
`endif
            end
         end
         ST_START: begin
            if (bit_done) begin
               state_d = ST_DATA;
               txd_d   = shift[0];
            end
         end
         ST_DATA: begin
            if (bit_done) begin
               shift_d = {1'b0, shift[7:1]};
               if (idx == LAST_DATA) begin
                  idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
                  txd_d   = par;
`else
                  state_d = ST_STOP;
                  txd_d   = 1'b1;
`endif
               end else begin
                  idx_d = idx + 3'd1;
                  txd_d = shift[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_done) begin
               state_d = ST_STOP;
               txd_d   = 1'b1;
            end
         end
`endif
         ST_STOP: begin
            txd_d = 1'b1;
            if (bit_done) begin
               if (idx == LAST_STOP) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx + 3'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         shift    <= '0;
         idx      <= '0;
         uart_txd <= 1'b1;
      end else begin
         state    <= state_d;
         shift    <= shift_d;
         idx      <= idx_d;
         uart_txd <= txd_d;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         par <= 1'b0;
      end else begin
         par <= par_d;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a frame-level line model,
// a per-cycle compare process and a mid-bit sampling receiver model.
module tb_uart_tx;

   localparam int CLK_HZ    = 1000000;
   localparam int BIT_RATE  = 100000;
   localparam int STOP_BITS = 1;
   localparam int CPB       = 10;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR   = 1'b1;
   localparam int FRAME = 110;
`else
   localparam bit PAR   = 1'b0;
   localparam int FRAME = 100;
`endif

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       tx_en = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       uart_txd;
   logic       tx_busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;

   uart_tx #(
      .BIT_RATE (BIT_RATE),
      .CLK_HZ   (CLK_HZ),
      .STOP_BITS(STOP_BITS)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .uart_txd(uart_txd),
      .tx_en   (tx_en),
      .tx_data (tx_data),
      .tx_busy (tx_busy)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h",
                  nm, cyc, act, exp);
      end
   endtask

   // Line model: a frame is a list of bit levels, each held CPB cycles.
   logic [1:0] q[$];
   logic       exp_txd  = 1'b1;
   logic       exp_busy = 1'b0;

   function automatic void build(input logic [7:0] d);
      bit lv[$];
      lv.push_back(1'b0);
      for (int i = 0; i < 8; i++) lv.push_back(d[i]);
      if (PAR) lv.push_back(^d);
      for (int s = 0; s < STOP_BITS; s++) lv.push_back(1'b1);
      foreach (lv[k])
         for (int c = 0; c < CPB; c++) q.push_back({lv[k], 1'b1});
   endfunction

   initial begin : model
      logic [1:0] e;
      forever begin
         @(posedge clk or negedge resetn);
         if (!resetn) begin
            q.delete();
            exp_txd  = 1'b1;
            exp_busy = 1'b0;
         end else begin
            if (q.size() == 0 && !exp_busy && tx_en) begin
               build(tx_data);
               chk("model_len", q.size(), FRAME);
            end
            if (q.size() > 0) begin
               e = q.pop_front();
               exp_txd  = e[1];
               exp_busy = e[0];
            end else begin
               exp_txd  = 1'b1;
               exp_busy = 1'b0;
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         chk("line_txd", uart_txd, exp_txd);
         chk("line_busy", tx_busy, exp_busy);
      end
   end

   // Receiver model: samples each bit in its middle.
   logic [7:0] rx_b[$];
   int         rx_t[$];
   bit         rx_p[$];
   bit         rx_ok[$];

   initial begin : rx
      logic [7:0] b;
      logic       sb, sp, pb;
      int         t0;
      forever begin
         @(negedge clk);
         if (resetn && uart_txd === 1'b0) begin
            t0 = cyc;
            pb = 1'b0;
            repeat (CPB / 2) @(negedge clk);
            sb = uart_txd;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = uart_txd;
            end
            if (PAR) begin
               repeat (CPB) @(negedge clk);
               pb = uart_txd;
            end
            repeat (CPB) @(negedge clk);
            sp = uart_txd;
            rx_b.push_back(b);
            rx_t.push_back(t0);
            rx_p.push_back(pb);
            rx_ok.push_back(!sb && sp);
         end
      end
   end

   task automatic rx_clear();
      rx_b.delete();
      rx_t.delete();
      rx_p.delete();
      rx_ok.delete();
   endtask

   task automatic send(input logic [7:0] d);
      @(negedge clk);
      tx_data = d;
      tx_en   = 1'b1;
      @(negedge clk);
      tx_en   = 1'b0;
   endtask

   task automatic wait_idle(input int max, output int n);
      n = 0;
      while (tx_busy && n < max) begin
         n++;
         @(negedge clk);
      end
      chk("idle_timeout", (n < max), 1);
   endtask

   task automatic chk_rx(input string nm, input int idx,
                         input logic [7:0] d);
      if (rx_b.size() > idx) begin
         chk({nm, "_byte"}, rx_b[idx], d);
         chk({nm, "_framing"}, rx_ok[idx], 1);
      end else begin
         chk({nm, "_missing"}, rx_b.size(), idx + 1);
      end
   endtask

   initial begin : stim
      int n;
      int bad;

      // 1: reset then idle
      repeat (3) @(negedge clk);
      chk("rst_txd", uart_txd, 1);
      chk("rst_busy", tx_busy, 0);
      resetn = 1'b1;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx_busy !== 1'b0 || uart_txd !== 1'b1) bad++;
      end
      chk("t1_idle", bad, 0);

      // 2: single 0x55 frame
      rx_clear();
      send(8'h55);
      wait_idle(300, n);
      chk("t2_busy_len", n, FRAME);
      repeat (20) @(negedge clk);
      chk("t2_count", rx_b.size(), 1);
      chk_rx("t2", 0, 8'h55);

      // 3: data change and tx_en while busy are ignored
      rx_clear();
      send(8'hA3);
      repeat (29) @(negedge clk);
      tx_data = 8'hFF;
      tx_en   = 1'b1;
      @(negedge clk);
      tx_en   = 1'b0;
      wait_idle(300, n);
      repeat (40) @(negedge clk);
      chk("t3_count", rx_b.size(), 1);
      chk_rx("t3", 0, 8'hA3);

      // 4: back-to-back on first idle cycle
      rx_clear();
      send(8'h00);
      n = 0;
      while (tx_busy && n < 300) begin
         n++;
         @(negedge clk);
      end
      chk("t4_gap_timeout", (n < 300), 1);
      tx_data = 8'hFF;
      tx_en   = 1'b1;
      @(negedge clk);
      tx_en   = 1'b0;
      wait_idle(300, n);
      repeat (30) @(negedge clk);
      chk("t4_count", rx_b.size(), 2);
      chk_rx("t4a", 0, 8'h00);
      chk_rx("t4b", 1, 8'hFF);
      if (rx_t.size() == 2)
         chk("t4_spacing", rx_t[1] - rx_t[0], FRAME + 1);

      // 5: reset mid-frame
      send(8'h0F);
      repeat (44) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("t5_txd", uart_txd, 1);
      chk("t5_busy", tx_busy, 0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      bad = 0;
      repeat (150) begin
         @(negedge clk);
         if (tx_busy !== 1'b0 || uart_txd !== 1'b1) bad++;
      end
      chk("t5_idle", bad, 0);
      rx_clear();

`ifdef UART_TX_PARITY_EN
      // 6: parity bit
      send(8'h55);
      wait_idle(300, n);
      chk("t6_busy_len", n, 110);
      repeat (20) @(negedge clk);
      chk_rx("t6a", 0, 8'h55);
      if (rx_p.size() > 0) chk("t6a_par", rx_p[0], 0);
      send(8'h01);
      wait_idle(300, n);
      repeat (20) @(negedge clk);
      chk_rx("t6b", 1, 8'h01);
      if (rx_p.size() > 1) chk("t6b_par", rx_p[1], 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
